fetch_queue: RTL and testbench

Instruction fetch queue between the instruction memory and the dual-issue decoder. Each cycle it accepts an aligned pair of instruction words plus the pair's PC from the fetch side and stores them in a circular buffer. The decoder takes 0, 1 or 2 instructions from the head in program order. The queue back-pressures the PC stage with `stall` and discards its whole contents on a taken jump or branch (`flush`).

---
 rtl/proc_pkg.sv | 9 +
 rtl/fetch_queue_mem.sv | 44 ++++
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor-wide constants for the fetch path.
package proc_pkg;

   localparam int unsigned WORD_W       = 32;
   localparam logic [31:0] NOP_INS      = 32'h0;
   // One fetched pair covers two words, so it advances both the PC and the queue write pointer by two.
   localparam int unsigned PC_PAIR_STEP = 2;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH entries of {ins, pc}, two adjacent write ports, two combinational read ports.
module fetch_queue_mem #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned WORD_W = 32,
   parameter int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr0_i,
   input  logic [AW-1:0]     waddr1_i,
   input  logic [WORD_W-1:0] wins0_i,
   input  logic [WORD_W-1:0] wpc0_i,
   input  logic [WORD_W-1:0] wins1_i,
   input  logic [WORD_W-1:0] wpc1_i,
   input  logic [AW-1:0]     raddr0_i,
   input  logic [AW-1:0]     raddr1_i,
   output logic [WORD_W-1:0] rins0_o,
   output logic [WORD_W-1:0] rpc0_o,
   output logic [WORD_W-1:0] rins1_o,
   output logic [WORD_W-1:0] rpc1_o
);

   logic [WORD_W-1:0] ins_q [DEPTH];
   logic [WORD_W-1:0] pc_q  [DEPTH];

   // Write both halves of an accepted pair; contents are intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         ins_q[waddr0_i] <= wins0_i;
         pc_q[waddr0_i]  <= wpc0_i;
         ins_q[waddr1_i] <= wins1_i;
         pc_q[waddr1_i]  <= wpc1_i;
      end
   end

   // Asynchronous head reads.
   always_comb begin
      rins0_o = ins_q[raddr0_i];
      rpc0_o  = pc_q[raddr0_i];
      rins1_o = ins_q[raddr1_i];
      rpc1_o  = pc_q[raddr1_i];
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: accepts aligned instruction pairs, hands 0..2 to the decoder in order.
module fetch_queue #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned WORD_W = proc_pkg::WORD_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [WORD_W-1:0]          in_ins0,
   input  logic [WORD_W-1:0]          in_ins1,
   input  logic [WORD_W-1:0]          in_pc,
   input  logic                       flush,
   input  logic [1:0]                 deq_cnt,
   output logic                       stall,
   output logic                       out_valid0,
   output logic                       out_valid1,
   output logic [WORD_W-1:0]          out_ins0,
   output logic [WORD_W-1:0]          out_ins1,
   output logic [WORD_W-1:0]          out_pc0,
   output logic [WORD_W-1:0]          out_pc1,
   output logic [$clog2(DEPTH):0]     count
);

   import proc_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [AW-1:0]     wr_addr1, rd_addr1;
   logic [1:0]        deq_req;
   logic [CW-1:0]     deq_eff;
   logic [CW-1:0]     enq_amt;
   logic              enq;
   logic [WORD_W-1:0] in_pc1;
   logic [WORD_W-1:0] rins0, rpc0, rins1, rpc1;

   // Stall looks only at registered occupancy, keeping deq_cnt/in_valid off the stall path.
   assign stall = count_q > CW'(DEPTH - 2);
   assign count = count_q;

   // Next-state for pointers and occupancy; flush overrides any enqueue or dequeue.
   always_comb begin
      deq_req  = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
      deq_eff  = (count_q < CW'(deq_req)) ? count_q : CW'(deq_req);
      enq      = in_valid && !stall && !flush;
      enq_amt  = enq ? CW'(PC_PAIR_STEP) : '0;
      wr_addr1 = wr_ptr_q + AW'(1);
      rd_addr1 = rd_ptr_q + AW'(1);
      in_pc1   = in_pc + WORD_W'(1);
      wr_ptr_d = enq ? wr_ptr_q + AW'(PC_PAIR_STEP) : wr_ptr_q;
      rd_ptr_d = rd_ptr_q + AW'(deq_eff);
      count_d  = count_q + enq_amt - deq_eff;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   fetch_queue_mem #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W),
      .AW     (AW)
   ) u_mem (
      .clk_i    (clk),
      .we_i     (enq),
      .waddr0_i (wr_ptr_q),
      .waddr1_i (wr_addr1),
      .wins0_i  (in_ins0),
      .wpc0_i   (in_pc),
      .wins1_i  (in_ins1),
      .wpc1_i   (in_pc1),
      .raddr0_i (rd_ptr_q),
      .raddr1_i (rd_addr1),
      .rins0_o  (rins0),
      .rpc0_o   (rpc0),
      .rins1_o  (rins1),
      .rpc1_o   (rpc1)
   );

   // Head outputs, zeroed (NOP) when the slot is empty.
   always_comb begin
      out_valid0 = count_q >= CW'(1);
      out_valid1 = count_q >= CW'(2);
      out_ins0   = out_valid0 ? rins0 : WORD_W'(NOP_INS);
      out_pc0    = out_valid0 ? rpc0  : '0;
      out_ins1   = out_valid1 ? rins1 : WORD_W'(NOP_INS);
      out_pc1    = out_valid1 ? rpc1  : '0;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH=8, WORD_W=32).
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_ins0, in_ins1, in_pc;
   logic        flush;
   logic [1:0]  deq_cnt;
   logic        stall, out_valid0, out_valid1;
   logic [31:0] out_ins0, out_ins1, out_pc0, out_pc1;
   logic [3:0]  count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   fetch_queue #(.DEPTH(8), .WORD_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ins0    (in_ins0),
      .in_ins1    (in_ins1),
      .in_pc      (in_pc),
      .flush      (flush),
      .deq_cnt    (deq_cnt),
      .stall      (stall),
      .out_valid0 (out_valid0),
      .out_valid1 (out_valid1),
      .out_ins0   (out_ins0),
      .out_ins1   (out_ins1),
      .out_pc0    (out_pc0),
      .out_pc1    (out_pc1),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] insw(input logic [31:0] pc);
      return 32'hC0DE0000 | {16'h0, pc[15:0]};
   endfunction

   task automatic drive_pair(input logic [31:0] pc);
      in_valid = 1'b1;
      in_pc    = pc;
      in_ins0  = insw(pc);
      in_ins1  = insw(pc + 32'd1);
   endtask

   int unsigned mcnt;
   logic [31:0] exp_head, pc_next;
   logic        acc;

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; deq_cnt = 2'd0;
      in_ins0 = '0; in_ins1 = '0; in_pc = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_count",  count, 0);
      check("rst_stall",  stall, 0);
      check("rst_v0",     out_valid0, 0);
      check("rst_v1",     out_valid1, 0);
      check("rst_ins0",   out_ins0, 0);
      check("rst_pc1",    out_pc1, 0);

      // first pair, no bypass, visible after one edge
      in_valid = 1'b1; in_pc = 32'h10; in_ins0 = 32'hAAAA0001; in_ins1 = 32'hAAAA0002;
      #1 check("nobypass_v0", out_valid0, 0);
      tick();
      check("p1_count", count, 2);
      check("p1_ins0",  out_ins0, 32'hAAAA0001);
      check("p1_pc0",   out_pc0, 32'h10);
      check("p1_ins1",  out_ins1, 32'hAAAA0002);
      check("p1_pc1",   out_pc1, 32'h11);
      check("p1_v0",    out_valid0, 1);
      check("p1_v1",    out_valid1, 1);

      // fill: 2 -> 4 -> 6 -> 8; stall only above DEPTH-2
      drive_pair(32'h12); tick();
      drive_pair(32'h14); tick();
      check("fill_count6", count, 6);
      check("fill_stall6", stall, 0);
      drive_pair(32'h16); tick();
      check("fill_count8", count, 8);
      check("fill_stall8", stall, 1);
      drive_pair(32'h18); tick();
      check("drop_count", count, 8);
      deq_cnt = 2'd2; tick();
      check("deq_count", count, 6);
      check("deq_stall", stall, 0);
      check("deq_pc0",   out_pc0, 32'h12);
      check("deq_ins1",  out_ins1, insw(32'h13));

      // stream with single dequeue; pointers wrap 7->0 several times
      mcnt = 6; exp_head = 32'h12; pc_next = 32'h18;
      for (int i = 0; i < 12; i++) begin
         drive_pair(pc_next);
         deq_cnt = 2'd1;
         acc = (mcnt <= 6);
         check("str_stall", stall, !acc);
         tick();
         if (mcnt > 0) begin mcnt--; exp_head++; end
         if (acc) begin mcnt += 2; pc_next += 32'd2; end
         check("str_count", count, mcnt);
         check("str_pc0",   out_pc0, exp_head);
         check("str_ins0",  out_ins0, insw(exp_head));
         check("str_pc1",   out_pc1, exp_head + 32'd1);
      end

      // drain down to one entry
      in_valid = 1'b0;
      deq_cnt = 2'd1; tick();
      mcnt--; exp_head++;
      for (int i = 0; i < 4 && mcnt > 1; i++) begin
         deq_cnt = 2'd2; tick();
         mcnt -= 2; exp_head += 32'd2;
      end
      check("one_count", count, 1);
      check("one_pc0",   out_pc0, exp_head);
      check("one_v1",    out_valid1, 0);
      check("one_ins1",  out_ins1, 0);
      check("one_pc1",   out_pc1, 0);
      deq_cnt = 2'd3; tick();
      check("empty_count", count, 0);
      check("empty_v0",    out_valid0, 0);
      check("empty_ins0",  out_ins0, 0);
      check("empty_pc0",   out_pc0, 0);
      // over-request on empty queue together with an enqueue
      drive_pair(32'h40); deq_cnt = 2'd2; tick();
      check("emptydeq_count", count, 2);
      check("emptydeq_pc0",   out_pc0, 32'h40);
      check("emptydeq_pc1",   out_pc1, 32'h41);

      // flush at count 5 with enqueue and dequeue present
      drive_pair(32'h42); deq_cnt = 2'd0; tick();
      drive_pair(32'h44); deq_cnt = 2'd1; tick();
      check("pre_flush_count", count, 5);
      check("pre_flush_pc0",   out_pc0, 32'h41);
      drive_pair(32'h50); deq_cnt = 2'd2; flush = 1'b1; tick();
      flush = 1'b0;
      check("flush_count", count, 0);
      check("flush_v0",    out_valid0, 0);
      check("flush_stall", stall, 0);
      drive_pair(32'h60); deq_cnt = 2'd0; tick();
      check("postflush_count", count, 2);
      check("postflush_pc0",   out_pc0, 32'h60);
      check("postflush_ins0",  out_ins0, insw(32'h60));

      // asynchronous reset between edges
      drive_pair(32'h62); tick();
      check("prerst_count", count, 4);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_count", count, 0);
      check("arst_v0",    out_valid0, 0);
      check("arst_v1",    out_valid1, 0);
      check("arst_ins0",  out_ins0, 0);
      check("arst_pc1",   out_pc1, 0);
      #2 rst = 1'b0;
      drive_pair(32'h70);
      #1 check("rel_v0", out_valid0, 0);
      tick();
      in_valid = 1'b0;
      check("rel_count", count, 2);
      check("rel_pc0",   out_pc0, 32'h70);
      check("rel_ins1",  out_ins1, insw(32'h71));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
